// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default line timing.
package uart_pkg;

    // Receiver FSM states; WAIT_IDLE is entered from reset and after a framing error.
    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    // Default clock and line rate, shared by receiver and transmitter.
    localparam int DEFAULT_CLOCK_FREQ = 125_000_000;
    localparam int DEFAULT_BAUD_RATE  = 115_200;

endpackage : uart_pkg

// File: rtl/uart_receiver_if.sv
// Byte output channel of the UART receiver, plus its error pulses.
//
// Handshake: the receiver (master) raises data_out_valid with data_out and
// holds both stable until a clk edge where data_out_valid and data_out_ready
// are both high; that edge is the transfer. Valid never depends
// combinationally on ready. framing_error and overrun are single-cycle
// pulses that carry no handshake.
interface uart_receiver_if;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       framing_error;
    logic       overrun;

    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready,
        output framing_error,
        output overrun
    );

    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready,
        input  framing_error,
        input  overrun
    );
endinterface : uart_receiver_if

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs, with a programmable reset value.
module synchronizer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; the first stage may go metastable, the second settles it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule : synchronizer

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled bit timing, start-glitch rejection,
// framing-error and overrun pulses, ready/valid byte output.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    uart_receiver_if.master   rx_if,
    output rx_state_t         dbg_state_o
);
    localparam int SYMBOL_EDGE_TIME    = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME         = SYMBOL_EDGE_TIME / 2;
    localparam int CLOCK_COUNTER_WIDTH = $clog2(SYMBOL_EDGE_TIME);

    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SYMBOL_LAST = CLOCK_COUNTER_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] SAMPLE_LAST = CLOCK_COUNTER_WIDTH'(SAMPLE_TIME - 1);
    localparam logic [CLOCK_COUNTER_WIDTH-1:0] CNT_ONE     = CLOCK_COUNTER_WIDTH'(1);

    logic rx;

    rx_state_t                      state_q,   state_d;
    logic [CLOCK_COUNTER_WIDTH-1:0] cnt_q,     cnt_d;
    logic [2:0]                     bit_idx_q, bit_idx_d;
    logic [7:0]                     shift_q,   shift_d;
    logic [7:0]                     data_q,    data_d;
    logic                           valid_q,   valid_d;
    logic                           fe_q,      fe_d;
    logic                           ov_q,      ov_d;

    // The line idles high, so the synchronizer resets to 1 to avoid a false start.
    synchronizer #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (reset),
        .d_i (serial_in),
        .q_o (rx)
    );

    // State, bit timing, shift register and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
        end
    end

    // Next-state logic: frame sequencing, bit sampling and byte delivery.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        // A pending byte is released by a handshake; a fresh load below overrides this.
        valid_d   = valid_q & ~rx_if.data_out_ready;
        fe_d      = 1'b0;
        ov_d      = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                // Require one full symbol of continuous high before trusting the line.
                if (rx) begin
                    if (cnt_q == SYMBOL_LAST) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            IDLE: begin
                cnt_d = '0;
                if (!rx) begin
                    state_d = START;
                end
            end

            START: begin
                // Re-check the start bit at its middle; a high here was a glitch.
                if (cnt_q == SAMPLE_LAST) begin
                    cnt_d = '0;
                    if (!rx) begin
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            DATA: begin
                // Mid-bit samples one symbol apart; LSB arrives first.
                if (cnt_q == SYMBOL_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            STOP: begin
                if (cnt_q == SYMBOL_LAST) begin
                    cnt_d = '0;
                    if (rx) begin
                        state_d = IDLE;
                        // Load only if the slot is free or is emptying on this edge.
                        if (!valid_q || rx_if.data_out_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ov_d = 1'b1;
                        end
                    end else begin
                        // Bad stop bit: drop the byte and resynchronise to an idle line.
                        fe_d    = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = WAIT_IDLE;
            end
        endcase
    end

    assign rx_if.data_out       = data_q;
    assign rx_if.data_out_valid = valid_q;
    assign rx_if.framing_error  = fe_q;
    assign rx_if.overrun        = ov_q;
    assign dbg_state_o          = state_q;
endmodule : uart_receiver
